// File: rtl/half_fp_pkg.sv
// Shared definitions for the binary16 multiplier datapath: FSM states, exponent limits,
// flag bit positions and canonical special encodings.
package half_fp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    DENORM,
    ROUND,
    HOLD
  } state_t;

  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;

  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;

  function automatic logic [2:0] mk_flags(input logic ovf, input logic unf, input logic inx);
    logic [2:0] f;
    f          = '0;
    f[FLG_OVF] = ovf;
    f[FLG_UNF] = unf;
    f[FLG_INX] = inx;
    return f;
  endfunction

endpackage

// File: rtl/half_fp_rne_round.sv
// Combinational round-to-nearest-even of a 1.20 fixed-point significand to 11 bits.
// o_carry flags a rollover into the next binade (bit 11 normal, bit 10 subnormal).
module half_fp_rne_round (
  input  logic [20:0] i_mant,
  input  logic        i_sticky,
  input  logic        i_sub,
  output logic [11:0] o_sig,
  output logic        o_carry,
  output logic        o_inexact
);

  logic w_g;
  logic w_s;
  logic w_inc;

  assign w_g       = i_mant[9];
  assign w_s       = (|i_mant[8:0]) | i_sticky;
  assign w_inc     = w_g & (w_s | i_mant[10]);
  assign o_sig     = {1'b0, i_mant[20:10]} + {11'b0, w_inc};
  assign o_carry   = i_sub ? o_sig[10] : o_sig[11];
  assign o_inexact = w_g | w_s;

endmodule

// File: rtl/half_fp_round_pack.sv
// Normalize / RNE round / pack to binary16; 1 to 17 cycles, result held until out_ready.
// HALF_FP_SUBNORMAL_EN builds gradual underflow; otherwise tiny results flush to signed zero.
module half_fp_round_pack
  import half_fp_pkg::*;
#(
  parameter int PROD_W = 22,
  parameter int EXP_W  = 7
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [PROD_W-1:0] in_mant,
  input  logic              in_special,
  input  logic [15:0]       in_special_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_result,
  output logic [2:0]        out_flags
);

  state_t                   r_state;
  logic                     r_sign;
  logic signed [EXP_W-1:0]  r_exp;
  logic [PROD_W-1:0]        r_mant;
  logic                     r_sticky;
  logic                     r_sub;

  logic [PROD_W-1:0]        w_nmant;
  logic signed [EXP_W-1:0]  w_nexp;
  logic                     w_nsticky;
  logic [11:0]              w_sig;
  logic                     w_carry;
  logic                     w_inx;
  logic [EXP_W-1:0]         w_rexp;

  assign in_ready  = (r_state == IDLE);

  // Product lies in [1,4): at most one right shift brings it into [1,2).
  assign w_nmant   = r_mant[PROD_W-1] ? (r_mant >> 1) : r_mant;
  assign w_nexp    = r_exp + EXP_W'(r_mant[PROD_W-1]);
  assign w_nsticky = r_sticky | (r_mant[PROD_W-1] & r_mant[0]);
  assign w_rexp    = r_exp + EXP_W'(w_carry);

  half_fp_rne_round u_rne (
    .i_mant    (r_mant[PROD_W-2:0]),
    .i_sticky  (r_sticky),
    .i_sub     (r_sub),
    .o_sig     (w_sig),
    .o_carry   (w_carry),
    .o_inexact (w_inx)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_mant     <= '0;
      r_sticky   <= 1'b0;
      r_sub      <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= 16'h0000;
      out_flags  <= 3'b000;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign   <= in_sign;
            r_exp    <= in_exp;
            r_mant   <= in_mant;
            r_sticky <= 1'b0;
            r_sub    <= 1'b0;
            if (in_special) begin
              out_result <= in_special_val;
              out_flags  <= '0;
              out_valid  <= 1'b1;
              r_state    <= HOLD;
            end else begin
              r_state <= NORM;
            end
          end
        end
        NORM: begin
          r_mant   <= w_nmant;
          r_exp    <= w_nexp;
          r_sticky <= w_nsticky;
          if (w_nexp >= EXP_MAX) begin
            out_result <= POS_INF | {r_sign, 15'h0};
            out_flags  <= mk_flags(1'b1, 1'b0, 1'b1);
            out_valid  <= 1'b1;
            r_state    <= HOLD;
          end else if (w_nexp <= 0) begin
`ifdef HALF_FP_SUBNORMAL_EN
            r_state <= DENORM;
`else
            out_result <= {r_sign, 15'h0};
            out_flags  <= mk_flags(1'b0, 1'b1, 1'b1);
            out_valid  <= 1'b1;
            r_state    <= HOLD;
`endif
          end else begin
            r_state <= ROUND;
          end
        end
`ifdef HALF_FP_SUBNORMAL_EN
        DENORM: begin
          r_mant   <= r_mant >> 1;
          r_exp    <= r_exp + EXP_W'(1);
          r_sticky <= r_sticky | r_mant[0];
          if (r_exp == '0 || r_mant[PROD_W-1:1] == '0) begin
            r_sub   <= 1'b1;
            r_state <= ROUND;
          end
        end
`endif
        ROUND: begin
          out_valid <= 1'b1;
          r_state   <= HOLD;
          // Tininess is judged before rounding, so a carry into exp=1 still reports underflow.
          if (r_sub) begin
            out_result <= {r_sign, 4'b0, w_sig[10], w_sig[9:0]};
            out_flags  <= mk_flags(1'b0, w_inx, w_inx);
          end else if (w_rexp >= EXP_W'(EXP_MAX)) begin
            out_result <= POS_INF | {r_sign, 15'h0};
            out_flags  <= mk_flags(1'b1, 1'b0, 1'b1);
          end else begin
            out_result <= {r_sign, w_rexp[4:0], w_sig[11] ? 10'h000 : w_sig[9:0]};
            out_flags  <= mk_flags(1'b0, 1'b0, w_inx);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_half_fp_round_pack.sv
// Directed and randomized checks of half_fp_round_pack against an exact-arithmetic model.
module tb_half_fp_round_pack;
  import half_fp_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [6:0]  in_exp = '0;
  logic [21:0] in_mant = '0;
  logic        in_special = 1'b0;
  logic [15:0] in_special_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic [2:0]  out_flags;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  half_fp_round_pack dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sign        (in_sign),
    .in_exp         (in_exp),
    .in_mant        (in_mant),
    .in_special     (in_special),
    .in_special_val (in_special_val),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_flags      (out_flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Exact rounding of v / 2^sh to nearest-even integer.
  function automatic longint rne(input longint v, input int sh, output logic inx);
    longint q, rem, half;
    q    = v >> sh;
    rem  = v - (q << sh);
    half = longint'(1) << (sh - 1);
    inx  = (rem != 0);
    if (rem > half || (rem == half && q[0])) q++;
    return q;
  endfunction

  // Value = m * 2^(e - 35); rounded into binary16 directly from that value.
  function automatic void ref_model(input logic sg, input int e, input int m,
                                    output logic [15:0] r, output logic [2:0] f, output int lat);
    int     top, eb;
    longint n;
    logic   inx;
    top = (m >= 32'h200000) ? 21 : 20;
    eb  = e + top - 20;
    r = '0; f = '0; lat = 0;
    if (eb >= EXP_MAX) begin
      r = POS_INF | {sg, 15'h0}; f = 3'b101; lat = 2;
    end else if (eb <= 0) begin
`ifdef HALF_FP_SUBNORMAL_EN
      n   = rne(longint'(m), 11 - e, inx);
      r   = {sg, 15'(n)};
      f   = {1'b0, inx, inx};
      lat = 3 + (1 - eb);
`else
      r = {sg, 15'h0}; f = 3'b011; lat = 2;
`endif
    end else begin
      n = rne(longint'(m), top - 10, inx);
      if (n == 2048) begin
        n = 1024;
        eb++;
      end
      lat = 3;
      if (eb >= EXP_MAX) begin
        r = POS_INF | {sg, 15'h0}; f = 3'b101;
      end else begin
        r = {sg, 5'(eb), 10'(n)}; f = {2'b00, inx};
      end
    end
  endfunction

  task automatic run_txn(input logic sg, input int e, input logic [21:0] m, input logic sp,
                         input logic [15:0] sv, input int hold,
                         output logic [15:0] r, output logic [2:0] f, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_sign = sg; in_exp = 7'(e); in_mant = m;
    in_special = sp; in_special_val = sv; out_ready = (hold == 0);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    // Garbage offered while busy must be ignored.
    in_valid = 1'($urandom_range(0, 1)); in_mant = 22'($urandom); in_exp = 7'($urandom);
    in_special = 1'($urandom_range(0, 1)); in_special_val = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      check("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_rise", 32'(out_valid), 32'd1);
    r = out_result; f = out_flags;
    for (int i = 0; i < hold; i++) begin
      check("hold_stable", 32'({out_valid, in_ready, out_result, out_flags}), 32'({1'b1, 1'b0, r, f}));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_handshake", 32'({out_valid, in_ready}), 32'b01);
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] r, er;
    logic [2:0]  f, ef;
    int          lat, el, a, b, e, hold;
    logic        sg, sp, stayed_low;
    logic [15:0] sv;

    #1 n_rst = 1'b0;
    #10;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", 32'(out_result), 32'h0000);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) n_rst = 1'b1;

    run_txn(1'b0, 15, 22'h100000, 1'b0, 16'h0, 0, r, f, lat);
    check("one_res", 32'(r), 32'h3C00);
    check("one_flags", 32'(f), 32'd0);
    check("one_lat", lat, 3);

    run_txn(1'b0, 15, 22'h240000, 1'b0, 16'h0, 0, r, f, lat);
    check("onehalf_sq_res", 32'(r), 32'h4080);
    check("onehalf_sq_flags", 32'(f), 32'd0);

    run_txn(1'b0, 15, 22'h100200, 1'b0, 16'h0, 1, r, f, lat);
    check("tie_even_res", 32'(r), 32'h3C00);
    check("tie_even_flags", 32'(f), 32'b001);

    run_txn(1'b0, 15, 22'h100600, 1'b0, 16'h0, 0, r, f, lat);
    check("tie_odd_res", 32'(r), 32'h3C02);
    check("tie_odd_flags", 32'(f), 32'b001);

    run_txn(1'b1, 31, 22'h100000, 1'b0, 16'h0, 0, r, f, lat);
    check("ovf_res", 32'(r), 32'hFC00);
    check("ovf_flags", 32'(f), 32'b101);
    check("ovf_lat", lat, 2);

    run_txn(1'b0, 30, 22'h1FFE00, 1'b0, 16'h0, 0, r, f, lat);
    check("round_ovf_res", 32'(r), 32'h7C00);
    check("round_ovf_flags", 32'(f), 32'b101);

    run_txn(1'b0, 0, 22'h100000, 1'b0, 16'h0, 0, r, f, lat);
`ifdef HALF_FP_SUBNORMAL_EN
    check("sub_res", 32'(r), 32'h0200);
    check("sub_flags", 32'(f), 32'b000);
    check("sub_lat", lat, 4);
`else
    check("ftz_res", 32'(r), 32'h0000);
    check("ftz_flags", 32'(f), 32'b011);
    check("ftz_lat", lat, 2);
`endif

    run_txn(1'b0, 15, 22'h0, 1'b1, QNAN, 5, r, f, lat);
    check("special_res", 32'(r), 32'h7E00);
    check("special_flags", 32'(f), 32'd0);
    check("special_lat", lat, 1);

    // Reset two cycles after accepting a deeply tiny operand.
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 7'(-13); in_mant = 22'h100000; in_special = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) n_rst = 1'b1;
    stayed_low = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stayed_low = 1'b0;
    end
    check("midrst_no_output", 32'(stayed_low), 32'd1);

    for (int t = 0; t < 200; t++) begin
      a    = int'($urandom_range(1024, 2047));
      b    = int'($urandom_range(1024, 2047));
      e    = int'($urandom_range(0, 58)) - 13;
      sg   = 1'($urandom_range(0, 1));
      sp   = ($urandom_range(0, 9) == 0);
      sv   = 16'($urandom);
      hold = int'($urandom_range(0, 2));
      if (sp) begin
        er = sv; ef = 3'b000; el = 1;
      end else begin
        ref_model(sg, e, a * b, er, ef, el);
      end
      run_txn(sg, e, 22'(a * b), sp, sv, hold, r, f, lat);
      check("rand_res", 32'(r), 32'(er));
      check("rand_flags", 32'(f), 32'(ef));
      check("rand_lat", lat, el);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
